// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bundle of the CDC FIFO: upstream valid/ready stream in, RAM write port out.
interface fifo_wr_ctrl_if #(
    parameter int width_p = 8,
    parameter int depth_p = 512
);
    localparam int A = $clog2(depth_p);

    logic               valid_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               wr_valid_o;
    logic [A-1:0]       wr_addr_o;
    logic [width_p-1:0] wr_data_o;

    modport slave (
        input  valid_i, data_i,
        output ready_o, wr_valid_o, wr_addr_o, wr_data_o
    );

    modport master (
        output valid_i, data_i,
        input  ready_o, wr_valid_o, wr_addr_o, wr_data_o
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the 1R1W CDC FIFO: pointers, Gray publish, read-pointer sync,
// full detection and write-side occupancy.
module fifo_wr_ctrl #(
    parameter int width_p = 8,
    parameter int depth_p = 512,
    localparam int A = $clog2(depth_p)
) (
    input  logic           cclk_i,
    input  logic           creset_i,
    fifo_wr_ctrl_if.slave  bus,
    output logic [A:0]     wr_ptr_gray_o,
    input  logic [A:0]     rd_ptr_gray_i,
    output logic           full_o,
    output logic [A:0]     count_o
);

    function automatic logic [A:0] bin2gray(input logic [A:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [A:0] gray2bin(input logic [A:0] g);
        logic [A:0] b;
        b[A] = g[A];
        for (int i = A - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [A:0] wr_bin_r;
    logic [A:0] wr_gray_r;
    logic [A:0] sync_s1;
    logic [A:0] sync_s2;
    logic [A:0] count_r;
    logic       full_r;

    logic       ready;
    logic       accept;
    logic [A:0] wr_bin_next;
    logic [A:0] wr_gray_next;
    logic [A:0] rd_bin_sync;
    logic [A:0] full_gray;

    assign ready        = ~full_r & ~creset_i;
    assign accept       = bus.valid_i & ready;
    assign wr_bin_next  = wr_bin_r + {{A{1'b0}}, accept};
    assign wr_gray_next = bin2gray(wr_bin_next);
    assign rd_bin_sync  = gray2bin(sync_s2);
    // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
    assign full_gray    = {~sync_s2[A:A-1], sync_s2[A-2:0]};

    always_ff @(posedge cclk_i) begin
        if (creset_i) begin
            wr_bin_r  <= '0;
            wr_gray_r <= '0;
            sync_s1   <= '0;
            sync_s2   <= '0;
            full_r    <= 1'b0;
            count_r   <= '0;
        end else begin
            wr_bin_r  <= wr_bin_next;
            wr_gray_r <= wr_gray_next;
            sync_s1   <= rd_ptr_gray_i;
            sync_s2   <= sync_s1;
            full_r    <= (wr_gray_next == full_gray);
            count_r   <= wr_bin_next - rd_bin_sync;
        end
    end

    assign bus.ready_o    = ready;
    assign bus.wr_valid_o = accept;
    assign bus.wr_addr_o  = wr_bin_r[A-1:0];
    assign bus.wr_data_o  = width_p'(bus.data_i);

    assign wr_ptr_gray_o  = wr_gray_r;
    assign full_o         = full_r;
    assign count_o        = count_r;

endmodule
